// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the MIPS pipeline hazard controller.
package pipe_pkg;

    localparam int unsigned REG_W           = 5;
    localparam int unsigned TNEW_W          = 2;
    localparam int unsigned STALL_CNT_W     = 32;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W_DEF       = 4;

    localparam logic [TNEW_W-1:0] TUSE_NONE = TNEW_W'(3);
    localparam logic [REG_W-1:0]  REG_ZERO  = 5'd0;

    typedef enum logic [1:0] {
        ACT_NORMAL = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_FLUSH  = 2'd2
    } hz_action_e;

    // One producer stage blocks D when it writes the source register too late for D's use.
    function automatic logic stage_blocks(
        input logic [REG_W-1:0]  src,
        input logic [TNEW_W-1:0] tuse,
        input logic [REG_W-1:0]  a3,
        input logic              regwe,
        input logic [TNEW_W-1:0] tnew
    );
        return regwe && (a3 == src) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-stage hazard inputs and register enable/clear outputs.
interface pipe_hazard_ctrl_if;
    import pipe_pkg::*;

    logic [REG_W-1:0]       D_rs;
    logic [REG_W-1:0]       D_rt;
    logic [TNEW_W-1:0]      D_Tuse_rs;
    logic [TNEW_W-1:0]      D_Tuse_rt;
    logic                   D_is_md;
    logic [REG_W-1:0]       E_A3;
    logic                   E_regwe;
    logic [TNEW_W-1:0]      E_Tnew;
    logic [REG_W-1:0]       M_A3;
    logic                   M_regwe;
    logic [TNEW_W-1:0]      M_Tnew;
    logic                   E_md_start;
    logic                   E_md_div;
    logic                   req;
    logic                   fd_en;
    logic                   d_clr;
    logic                   e_clr;
    logic                   m_clr;
    logic                   w_clr;
    logic                   md_busy;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
        output E_A3, E_regwe, E_Tnew, M_A3, M_regwe, M_Tnew,
        output E_md_start, E_md_div, req,
        input  fd_en, d_clr, e_clr, m_clr, w_clr, md_busy, stall_cnt
    );

    modport slave (
        input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
        input  E_A3, E_regwe, E_Tnew, M_A3, M_regwe, M_Tnew,
        input  E_md_start, E_md_div, req,
        output fd_en, d_clr, e_clr, m_clr, w_clr, md_busy, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// Countdown for the multi-cycle mult/div unit; busy is registered from the next count.
module md_busy_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             busy_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage MIPS pipeline.
// Optional stall-cycle counter enabled by defining STALL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);

    logic       stall_rs, stall_rt, stall_md, stall;
    logic       md_load;
    hz_action_e act;

    // W always forwards in time, so only E and M are compared.
    always_comb begin
        stall_rs = (hz.D_rs != REG_ZERO) &&
                   (stage_blocks(hz.D_rs, hz.D_Tuse_rs, hz.E_A3, hz.E_regwe, hz.E_Tnew) ||
                    stage_blocks(hz.D_rs, hz.D_Tuse_rs, hz.M_A3, hz.M_regwe, hz.M_Tnew));
        stall_rt = (hz.D_rt != REG_ZERO) &&
                   (stage_blocks(hz.D_rt, hz.D_Tuse_rt, hz.E_A3, hz.E_regwe, hz.E_Tnew) ||
                    stage_blocks(hz.D_rt, hz.D_Tuse_rt, hz.M_A3, hz.M_regwe, hz.M_Tnew));
        stall_md = hz.D_is_md && (hz.md_busy || hz.E_md_start);
        stall    = stall_rs || stall_rt || stall_md;
    end

    // Reset forces the free-running state so no register is gated while reset is low.
    always_comb begin
        act = ACT_NORMAL;
        if (!reset) begin
            act = ACT_NORMAL;
        end else if (hz.req) begin
            act = ACT_FLUSH;
        end else if (stall) begin
            act = ACT_STALL;
        end
    end

    always_comb begin
        hz.fd_en = 1'b1;
        hz.d_clr = 1'b0;
        hz.e_clr = 1'b0;
        hz.m_clr = 1'b0;
        hz.w_clr = 1'b0;
        unique case (act)
            ACT_FLUSH: begin
                hz.d_clr = 1'b1;
                hz.e_clr = 1'b1;
                hz.m_clr = 1'b1;
                hz.w_clr = 1'b1;
            end
            ACT_STALL: begin
                hz.fd_en = 1'b0;
                hz.e_clr = 1'b1;
            end
            default: ;
        endcase
    end

    // A flushed E instruction never starts the md unit.
    assign md_load = hz.E_md_start && !hz.req;

    md_busy_timer #(
        .CNT_W (CNT_W)
    ) u_md_timer (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (md_load),
        .load_val_i (hz.E_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)),
        .busy_o     (hz.md_busy)
    );

`ifdef STALL_PERF_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (act == ACT_STALL) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
`else
    assign hz.stall_cnt = '0;
`endif

endmodule
